// File: rtl/video_timing_gen.sv
// Raster timing generator for the 1280x720 HDMI path: registered pixel coordinates,
// per-frame strobe and frame counter, plus hsync/vsync/de delayed to match pixel latency.
module video_timing_gen #(
  parameter int HRES       = 1280,
  parameter int HFP        = 110,
  parameter int HSW        = 40,
  parameter int HBP        = 220,
  parameter int VRES       = 720,
  parameter int VFP        = 5,
  parameter int VSW        = 5,
  parameter int VBP        = 20,
  parameter bit SYNC_POL   = 1'b1,
  parameter int PIPE_DELAY = 1
) (
  input  logic               pixel_clk,
  input  logic               rst,
  output logic signed [11:0] hpos,
  output logic signed [11:0] vpos,
  output logic               fsync,
  output logic [15:0]        frame_cnt,
  output logic               hsync,
  output logic               vsync,
  output logic               de
);

  localparam int HTOTAL = HRES + HFP + HSW + HBP;
  localparam int VTOTAL = VRES + VFP + VSW + VBP;

  if (HTOTAL > 2047 || VTOTAL > 2047) begin : g_bad_total
    $error("video_timing_gen: HTOTAL/VTOTAL must not exceed 2047");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
    $error("video_timing_gen: PIPE_DELAY must be within 0..4");
  end

  localparam logic [10:0] H_LAST     = 11'(HTOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(VTOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(HRES);
  localparam logic [10:0] V_ACT      = 11'(VRES);
  localparam logic [10:0] HS_START   = 11'(HRES + HFP);
  localparam logic [10:0] HS_END     = 11'(HRES + HFP + HSW);
  localparam logic [10:0] VS_START   = 11'(VRES + VFP);
  localparam logic [10:0] VS_END     = 11'(VRES + VFP + VSW);
  localparam logic [2:0]  QUAL_RESET = {~SYNC_POL, ~SYNC_POL, 1'b0};

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } qual_t;

  logic [10:0] h_q, v_q;
  logic [10:0] h_nxt, v_nxt;
  logic        run_q;
  qual_t       qual_nxt, qual_q;
  logic        fsync_nxt;

  // The first edge after reset release only arms the counters, so 0,0 is shown for a full cycle.
  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    h_nxt = h_q;
    v_nxt = v_q;
    if (run_q) begin
      if (h_q == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
        h_nxt = h_q + 11'd1;
      end
    end
  end

  // Qualifiers are decoded from the next counter values so that, once registered,
  // they line up with hpos/vpos on the same cycle.
  always_comb begin
    qual_nxt.de = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    qual_nxt.hs = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    qual_nxt.vs = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    fsync_nxt   = (h_nxt == 11'd0) && (v_nxt == V_ACT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      run_q     <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      qual_q    <= QUAL_RESET;
      fsync     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      run_q  <= 1'b1;
      h_q    <= h_nxt;
      v_q    <= v_nxt;
      qual_q <= qual_nxt;
      fsync  <= fsync_nxt;
      if (fsync_nxt) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign hpos = signed'({1'b0, h_q});
  assign vpos = signed'({1'b0, v_q});

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign {hsync, vsync, de} = qual_q;
  end else begin : g_delay
    qual_t pipe_q [PIPE_DELAY];

    // NOTE: every delay stage is reset, otherwise the encoder would see stale sync/de after reset.
    always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          pipe_q[i] <= QUAL_RESET;
        end
      end else begin
        pipe_q[0] <= qual_q;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign {hsync, vsync, de} = pipe_q[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: four video_timing_gen instances (default, PIPE_DELAY 0 with low sync,
// PIPE_DELAY 4, small raster) compared every cycle against an arithmetic raster model.
module tb_video_timing_gen;

  localparam int N = 4;
  localparam int P_HRES [N] = '{1280, 1280, 1280, 8};
  localparam int P_HFP  [N] = '{110, 110, 110, 2};
  localparam int P_HSW  [N] = '{40, 40, 40, 2};
  localparam int P_HBP  [N] = '{220, 220, 220, 2};
  localparam int P_VRES [N] = '{720, 720, 720, 4};
  localparam int P_VFP  [N] = '{5, 5, 5, 1};
  localparam int P_VSW  [N] = '{5, 5, 5, 1};
  localparam int P_VBP  [N] = '{20, 20, 20, 1};
  localparam int P_POL  [N] = '{1, 0, 1, 1};
  localparam int P_PD   [N] = '{1, 0, 4, 1};

  typedef struct {
    int hpos;
    int vpos;
    int fsync;
    int frame_cnt;
    int hsync;
    int vsync;
    int de;
  } exp_t;

  logic               pixel_clk;
  logic               rst;
  logic signed [11:0] hpos_w  [N];
  logic signed [11:0] vpos_w  [N];
  logic               fsync_w [N];
  logic [15:0]        fc_w    [N];
  logic               hs_w    [N];
  logic               vs_w    [N];
  logic               de_w    [N];

  int     errors;
  int     checks;
  longint t;
  longint fc_base [N];

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  video_timing_gen u_def (
    .pixel_clk(pixel_clk), .rst(rst), .hpos(hpos_w[0]), .vpos(vpos_w[0]), .fsync(fsync_w[0]),
    .frame_cnt(fc_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]), .de(de_w[0])
  );

  video_timing_gen #(.SYNC_POL(1'b0), .PIPE_DELAY(0)) u_pd0 (
    .pixel_clk(pixel_clk), .rst(rst), .hpos(hpos_w[1]), .vpos(vpos_w[1]), .fsync(fsync_w[1]),
    .frame_cnt(fc_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]), .de(de_w[1])
  );

  video_timing_gen #(.PIPE_DELAY(4)) u_pd4 (
    .pixel_clk(pixel_clk), .rst(rst), .hpos(hpos_w[2]), .vpos(vpos_w[2]), .fsync(fsync_w[2]),
    .frame_cnt(fc_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]), .de(de_w[2])
  );

  video_timing_gen #(
    .HRES(8), .HFP(2), .HSW(2), .HBP(2), .VRES(4), .VFP(1), .VSW(1), .VBP(1),
    .SYNC_POL(1'b1), .PIPE_DELAY(1)
  ) u_small (
    .pixel_clk(pixel_clk), .rst(rst), .hpos(hpos_w[3]), .vpos(vpos_w[3]), .fsync(fsync_w[3]),
    .frame_cnt(fc_w[3]), .hsync(hs_w[3]), .vsync(vs_w[3]), .de(de_w[3])
  );

  function automatic longint htot(int k);
    return longint'(P_HRES[k] + P_HFP[k] + P_HSW[k] + P_HBP[k]);
  endfunction

  function automatic longint vtot(int k);
    return longint'(P_VRES[k] + P_VFP[k] + P_VSW[k] + P_VBP[k]);
  endfunction

  // Strobes seen up to and including cycle tt: the first lands after VRES whole lines,
  // then one per frame period.
  function automatic longint frames_at(int k, longint tt);
    longint first;
    first = longint'(P_VRES[k]) * htot(k);
    if (tt < first) return 0;
    return (tt - first) / (htot(k) * vtot(k)) + 1;
  endfunction

  function automatic exp_t reset_exp(int k);
    exp_t e;
    e.hpos = 0; e.vpos = 0; e.fsync = 0; e.frame_cnt = 0;
    e.hsync = 1 - P_POL[k]; e.vsync = 1 - P_POL[k]; e.de = 0;
    return e;
  endfunction

  // Expected outputs tt cycles after the first post-reset cycle.
  function automatic exp_t model(int k, longint tt);
    exp_t   e;
    longint u, uh, uv;
    e.hpos      = int'(tt % htot(k));
    e.vpos      = int'((tt / htot(k)) % vtot(k));
    e.fsync     = (e.hpos == 0 && e.vpos == P_VRES[k]) ? 1 : 0;
    e.frame_cnt = int'((fc_base[k] + frames_at(k, tt)) % 65536);
    u = tt - P_PD[k];
    if (u < 0) begin
      e.hsync = 1 - P_POL[k]; e.vsync = 1 - P_POL[k]; e.de = 0;
    end else begin
      uh = u % htot(k);
      uv = (u / htot(k)) % vtot(k);
      e.de = (uh < P_HRES[k] && uv < P_VRES[k]) ? 1 : 0;
      e.hsync = (uh >= P_HRES[k] + P_HFP[k] && uh < P_HRES[k] + P_HFP[k] + P_HSW[k])
                ? P_POL[k] : 1 - P_POL[k];
      e.vsync = (uv >= P_VRES[k] + P_VFP[k] && uv < P_VRES[k] + P_VFP[k] + P_VSW[k])
                ? P_POL[k] : 1 - P_POL[k];
    end
    return e;
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s inst=%0d t=%0d observed=%0d expected=%0d", tag, k, t, obs, expv);
    end
  endtask

  task automatic check_inst(input int k, input exp_t e);
    check("hpos", k, 32'(unsigned'(hpos_w[k])), 32'(e.hpos));
    check("vpos", k, 32'(unsigned'(vpos_w[k])), 32'(e.vpos));
    check("fsync", k, 32'(fsync_w[k]), 32'(e.fsync));
    check("frame_cnt", k, 32'(fc_w[k]), 32'(e.frame_cnt));
    check("hsync", k, 32'(hs_w[k]), 32'(e.hsync));
    check("vsync", k, 32'(vs_w[k]), 32'(e.vsync));
    check("de", k, 32'(de_w[k]), 32'(e.de));
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      check_inst(k, rst ? reset_exp(k) : model(k, t));
    end
  endtask

  // Advance n clocks, comparing every instance on each falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge pixel_clk);
      if (!rst) t++;
      @(negedge pixel_clk);
      check_all();
    end
  endtask

  // Assert reset between edges, confirm the immediate effect, hold it, then release.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check_all();
    step(3);
    #2 rst = 1'b0;
    t = -1;
    for (int k = 0; k < N; k++) fc_base[k] = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    t      = -1;
    for (int k = 0; k < N; k++) fc_base[k] = 0;
    rst = 1'b1;

    step(3);
    #2 rst = 1'b0;

    // Two full default lines and many small-raster frames, including frame_cnt steps.
    step(3400);

    // Reset at hpos = 500 of the default raster, then restart cleanly.
    async_reset();
    step(501);
    async_reset();
    step(200);

    // Resets at random points of the raster.
    repeat (3) begin
      step($urandom_range(1800, 60));
      async_reset();
      step($urandom_range(40, 5));
    end

    // Preload the small raster's frame counter to 0xFFFF; the next strobe must wrap it to 0.
    step(50);
    force u_small.frame_cnt = 16'hFFFF;
    #1 release u_small.frame_cnt;
    fc_base[3] = (65535 - frames_at(3, t)) % 65536;
    #1 check_inst(3, model(3, t));
    step(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
